mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the write-back stage.
- Holds one instruction and waits for the data-SRAM response of any memory request issued in EX.
- Aligns and extends load data, and forwards the result plus bypass information to decode.
- Handles pipeline flush from WB, including discarding data_ok responses that belong to cancelled requests.

Parameters:
PASS_WD, 82, width of CSR/exception pass-through field (csr_wvalue, ertn, syscall, csr_re, csr_we, csr_num, csr_wmask), carried unmodified
ES_TO_MS_WD, 75+PASS_WD, input bus width
MS_TO_WS_WD, 70+PASS_WD, output bus width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
es_to_ms_valid  in  1  EX holds a valid instruction for MS
es_to_ms_bus  in  ES_TO_MS_WD  {pass[ES_TO_MS_WD-1:75], ld_type[74:72], load_op[71], mem_req[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
ms_allowin  out  1  MS can accept this cycle
ws_allowin  in  1  WB can accept this cycle
ms_to_ws_valid  out  1  valid instruction presented to WB
ms_to_ws_bus  out  MS_TO_WS_WD  {pass, gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
flush  in  1  WB exception/ertn flush, kills the MS instruction
data_sram_data_ok  in  1  response strobe for an accepted data request
data_sram_rdata  in  32  response data, valid with data_ok
ms_fwd_bus  out  39  {fwd_we[38], load_wait[37], dest[36:32], final_result[31:0]} to decode

Behaviour:
- Reset values: ms_valid=0, rdata_buf_valid=0, cancel_cnt=0, bus register=0. Outputs: ms_to_ws_valid=0, ms_allowin=1, ms_fwd_bus=0.
- Valid register:
  - flush -> ms_valid<=0.
  - else if ms_allowin -> ms_valid<=es_to_ms_valid.
  - Bus register loads when es_to_ms_valid && ms_allowin && !flush.
- ms_ready_go = !mem_req || rdata_buf_valid || (data_sram_data_ok && cancel_cnt==0).
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go && !flush. This is combinational; latency is one cycle when no wait.
- Response buffer:
  - data_ok with cancel_cnt==0 and ms_valid && mem_req && !rdata_buf_valid, but no advance (ws_allowin=0): capture rdata into rdata_buf and set rdata_buf_valid.
  - Clear rdata_buf_valid when the instruction leaves (ms_ready_go && ws_allowin) or on flush.
  - Each request takes exactly one data_ok.
- Cancel counter (2-bit, saturating at 3):
  - On flush with ms_valid && mem_req && !rdata_buf_valid && !(data_ok this cycle with cancel_cnt==0): cancel_cnt+1.
  - While cancel_cnt>0, each data_ok decrements it and is ignored.
  - A simultaneous increment and decrement leaves cancel_cnt unchanged.
- mem_data selects rdata_buf if rdata_buf_valid, else data_sram_rdata.
- Load extraction from alu_result[1:0]. Byte select is mem_data[8*a+7:8*a]; halfword select uses a[1] (a[0] is assumed 0, alignment checked upstream).
  - ld_type 0 LD_B: sign-extend byte.
  - ld_type 1 LD_H: sign-extend halfword.
  - ld_type 2 LD_W: full word.
  - ld_type 4 LD_BU: zero-extend byte.
  - ld_type 5 LD_HU: zero-extend halfword.
  - Other codes produce the full word.
- final_result = load_op ? extracted : alu_result. Stores have mem_req=1, load_op=0: they wait for data_ok but forward alu_result.
- Forwarding:
  - fwd_we = ms_valid && gr_we && dest!=0.
  - load_wait = ms_valid && load_op && !ms_ready_go (decode must stall).
- Reset mid-wait clears everything. Responses arriving after reset are ignored because ms_valid=0 and mem_req is no longer registered.

Test Plan:
- ALU op pc=0x1c000000, alu_result=0x12345678, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x12345678, ms_allowin=1.
- LD_B addr 0x..03, data_ok 2 cycles after entry with rdata 0x80FF0102 -> load_wait=1 for 2 cycles, then final_result=0xFFFFFF80; LD_BU gives 0x00000080.
- LD_HU addr 0x..02, rdata 0xBEEF1234, data_ok while ws_allowin=0 -> rdata buffered; when ws_allowin=1 final_result=0x0000BEEF, no second data_ok needed.
- Flush while load waiting -> ms_valid=0, cancel_cnt=1. The next load enters, and the first data_ok (0xDEAD0000) is discarded. The second data_ok (0x00000011) gives LD_W result 0x00000011.
- Simultaneous flush and data_ok with cancel_cnt==0 -> cancel_cnt stays 0, ms_to_ws_valid=0 that cycle.
- Reset asserted during wait -> next cycle ms_valid=0, ms_allowin=1, ms_fwd_bus=0, cancel_cnt=0.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: waits for data SRAM response, aligns loads, forwards to WB and decode
module mem_stage #(
  parameter int PASS_WD     = 82,
  parameter int ES_TO_MS_WD = 75 + PASS_WD,
  parameter int MS_TO_WS_WD = 70 + PASS_WD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   es_to_ms_valid,
  input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
  output logic                   ms_allowin,
  input  logic                   ws_allowin,
  output logic                   ms_to_ws_valid,
  output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
  input  logic                   flush,
  input  logic                   data_sram_data_ok,
  input  logic [31:0]            data_sram_rdata,
  output logic [38:0]            ms_fwd_bus
);

  localparam logic [2:0] LD_B  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_W  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd4;
  localparam logic [2:0] LD_HU = 3'd5;

  logic                   ms_valid;
  logic [ES_TO_MS_WD-1:0] bus_r;
  logic                   rdata_buf_valid;
  logic [31:0]            rdata_buf;
  logic [1:0]             cancel_cnt;

  logic [PASS_WD-1:0] pass;
  logic [2:0]         ld_type;
  logic               load_op;
  logic               mem_req;
  logic               gr_we;
  logic [4:0]         dest;
  logic [31:0]        alu_result;
  logic [31:0]        pc;

  assign pass       = bus_r[ES_TO_MS_WD-1:75];
  assign ld_type    = bus_r[74:72];
  assign load_op    = bus_r[71];
  assign mem_req    = bus_r[70];
  assign gr_we      = bus_r[69];
  assign dest       = bus_r[68:64];
  assign alu_result = bus_r[63:32];
  assign pc         = bus_r[31:0];

  // A response only belongs to the current instruction once all cancelled responses have drained.
  logic resp_ok;
  logic ms_ready_go;
  logic ms_leave;
  logic cnt_inc;
  logic cnt_dec;

  assign resp_ok     = data_sram_data_ok && (cancel_cnt == 2'd0);
  assign ms_ready_go = !mem_req || rdata_buf_valid || resp_ok;
  assign ms_leave    = ms_ready_go && ws_allowin;
  assign ms_allowin  = !ms_valid || ms_leave;
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;

  // A flushed instruction still owes one response unless it already has it or gets it now.
  assign cnt_inc = flush && ms_valid && mem_req && !rdata_buf_valid && !resp_ok;
  assign cnt_dec = data_sram_data_ok && (cancel_cnt != 2'd0);

  // Valid bit: flush kills, otherwise follow EX whenever we can accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Instruction payload register.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_r <= '0;
    end else if (es_to_ms_valid && ms_allowin && !flush) begin
      bus_r <= es_to_ms_bus;
    end
  end

  // Hold a response that arrived while WB was stalled so it is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_buf_valid <= 1'b0;
      rdata_buf       <= 32'd0;
    end else if (flush || ms_leave) begin
      rdata_buf_valid <= 1'b0;
    end else if (resp_ok && ms_valid && mem_req && !rdata_buf_valid) begin
      rdata_buf_valid <= 1'b1;
      rdata_buf       <= data_sram_rdata;
    end
  end

  // Count responses still in flight for cancelled requests, saturating at 3.
  always_ff @(posedge clk) begin
    if (reset) begin
      cancel_cnt <= 2'd0;
    end else if (cnt_inc && !cnt_dec) begin
      if (cancel_cnt != 2'd3) begin
        cancel_cnt <= cancel_cnt + 2'd1;
      end
    end else if (cnt_dec && !cnt_inc) begin
      cancel_cnt <= cancel_cnt - 2'd1;
    end
  end

  logic [31:0] mem_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_result;
  logic [31:0] final_result;

  assign mem_data = rdata_buf_valid ? rdata_buf : data_sram_rdata;
  assign sel_half = alu_result[1] ? mem_data[31:16] : mem_data[15:0];

  // Byte lane picked by the low address bits.
  always_comb begin
    sel_byte = mem_data[7:0];
    case (alu_result[1:0])
      2'd0: sel_byte = mem_data[7:0];
      2'd1: sel_byte = mem_data[15:8];
      2'd2: sel_byte = mem_data[23:16];
      2'd3: sel_byte = mem_data[31:24];
      default: sel_byte = mem_data[7:0];
    endcase
  end

  // Sign/zero extension by load type; unknown codes return the whole word.
  always_comb begin
    load_result = mem_data;
    case (ld_type)
      LD_B:    load_result = {{24{sel_byte[7]}}, sel_byte};
      LD_H:    load_result = {{16{sel_half[15]}}, sel_half};
      LD_W:    load_result = mem_data;
      LD_BU:   load_result = {24'd0, sel_byte};
      LD_HU:   load_result = {16'd0, sel_half};
      default: load_result = mem_data;
    endcase
  end

  assign final_result = load_op ? load_result : alu_result;

  assign ms_to_ws_bus = {pass, gr_we, dest, final_result, pc};
  assign ms_fwd_bus   = {ms_valid && gr_we && (dest != 5'd0),
                         ms_valid && load_op && !ms_ready_go,
                         dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;
  localparam int PASS_WD = 82;
  localparam int ES = 75 + PASS_WD;
  localparam int MS = 70 + PASS_WD;

  logic          clk = 1'b0;
  logic          reset;
  logic          es_to_ms_valid;
  logic [ES-1:0] es_to_ms_bus;
  logic          ms_allowin;
  logic          ws_allowin;
  logic          ms_to_ws_valid;
  logic [MS-1:0] ms_to_ws_bus;
  logic          flush;
  logic          data_sram_data_ok;
  logic [31:0]   data_sram_rdata;
  logic [38:0]   ms_fwd_bus;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.PASS_WD(PASS_WD)) dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .flush(flush), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .ms_fwd_bus(ms_fwd_bus)
  );

  function automatic logic [ES-1:0] mk_bus(input logic [PASS_WD-1:0] pass, input logic [2:0] ld_type,
                                           input logic load_op, input logic mem_req, input logic gr_we,
                                           input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc);
    return {pass, ld_type, load_op, mem_req, gr_we, dest, alu, pc};
  endfunction

  function automatic logic [PASS_WD-1:0] rand_pass();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[PASS_WD-1:0];
  endfunction

  // Reference load: shift the word down by the byte offset, mask, then extend arithmetically.
  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] b;
    logic [31:0] h;
    b = (data >> (8 * addr[1:0])) & 32'hFF;
    h = (data >> (16 * addr[1])) & 32'hFFFF;
    case (t)
      3'd0: return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      3'd1: return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return data;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_allowin = 1'b1;
    flush = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", ms_to_ws_valid); end
    n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %0b want 1", ms_allowin); end
    n_cmp++; if (ms_fwd_bus !== 39'd0) begin n_fail++; $display("FAIL reset_fwd: got %h want 0", ms_fwd_bus); end
  endtask

  task automatic test_alu();
    logic [PASS_WD-1:0] p;
    p = rand_pass();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(p, 3'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h12345678, 32'h1c000000);
    ws_allowin = 1'b1;
    #1;
    n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL alu_allowin_empty: got %0b want 1", ms_allowin); end
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %0b want 1", ms_to_ws_valid); end
    n_cmp++; if (ms_to_ws_bus !== {p, 1'b1, 5'd5, 32'h12345678, 32'h1c000000}) begin n_fail++; $display("FAIL alu_bus: got %h want %h", ms_to_ws_bus, {p, 1'b1, 5'd5, 32'h12345678, 32'h1c000000}); end
    n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL alu_allowin: got %0b want 1", ms_allowin); end
    n_cmp++; if (ms_fwd_bus !== {1'b1, 1'b0, 5'd5, 32'h12345678}) begin n_fail++; $display("FAIL alu_fwd: got %h want %h", ms_fwd_bus, {1'b1, 1'b0, 5'd5, 32'h12345678}); end
    tick();
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL alu_drained: got %0b want 0", ms_to_ws_valid); end
  endtask

  task automatic test_load_wait(input logic [2:0] t, input logic [31:0] exp);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(rand_pass(), t, 1'b1, 1'b1, 1'b1, 5'd7, 32'h1c000103, 32'h1c000040);
    tick();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (ms_fwd_bus[37] !== 1'b1) begin n_fail++; $display("FAIL ld%0d_load_wait_c%0d: got %0b want 1", t, i, ms_fwd_bus[37]); end
      n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL ld%0d_wait_valid_c%0d: got %0b want 0", t, i, ms_to_ws_valid); end
      tick();
      data_sram_rdata = $urandom;
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h80FF0102;
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL ld%0d_valid: got %0b want 1", t, ms_to_ws_valid); end
    n_cmp++; if (ms_to_ws_bus[63:32] !== exp) begin n_fail++; $display("FAIL ld%0d_result: got %h want %h", t, ms_to_ws_bus[63:32], exp); end
    n_cmp++; if (ms_fwd_bus[37] !== 1'b0) begin n_fail++; $display("FAIL ld%0d_load_wait_done: got %0b want 0", t, ms_fwd_bus[37]); end
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL ld%0d_drained: got %0b want 0", t, ms_to_ws_valid); end
  endtask

  task automatic test_buffered();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(rand_pass(), 3'd5, 1'b1, 1'b1, 1'b1, 5'd9, 32'h1c000202, 32'h1c000080);
    tick();
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hBEEF1234;
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL buf_valid_resp: got %0b want 1", ms_to_ws_valid); end
    n_cmp++; if (ms_allowin !== 1'b0) begin n_fail++; $display("FAIL buf_allowin_stall: got %0b want 0", ms_allowin); end
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h55555555;
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL buf_valid_held: got %0b want 1", ms_to_ws_valid); end
    n_cmp++; if (ms_to_ws_bus[63:32] !== 32'h0000BEEF) begin n_fail++; $display("FAIL buf_result_held: got %h want 0000beef", ms_to_ws_bus[63:32]); end
    tick();
    ws_allowin = 1'b1;
    #1;
    n_cmp++; if (ms_to_ws_bus[63:32] !== 32'h0000BEEF) begin n_fail++; $display("FAIL buf_result_go: got %h want 0000beef", ms_to_ws_bus[63:32]); end
    n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL buf_allowin_go: got %0b want 1", ms_allowin); end
    tick();
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL buf_drained: got %0b want 0", ms_to_ws_valid); end
  endtask

  task automatic test_flush_cancel();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(rand_pass(), 3'd2, 1'b1, 1'b1, 1'b1, 5'd3, 32'h1c000300, 32'h1c0000c0);
    tick();
    es_to_ms_valid = 1'b0;
    flush = 1'b1;
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL fc_valid_flush: got %0b want 0", ms_to_ws_valid); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (dut.cancel_cnt !== 2'd1) begin n_fail++; $display("FAIL fc_cnt_one: got %0d want 1", dut.cancel_cnt); end
    n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL fc_allowin: got %0b want 1", ms_allowin); end
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(rand_pass(), 3'd2, 1'b1, 1'b1, 1'b1, 5'd4, 32'h1c000400, 32'h1c0000c4);
    tick();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEAD0000;
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL fc_stale_valid: got %0b want 0", ms_to_ws_valid); end
    n_cmp++; if (ms_fwd_bus[37] !== 1'b1) begin n_fail++; $display("FAIL fc_stale_wait: got %0b want 1", ms_fwd_bus[37]); end
    tick();
    data_sram_rdata = 32'h00000011;
    #1;
    n_cmp++; if (dut.cancel_cnt !== 2'd0) begin n_fail++; $display("FAIL fc_cnt_zero: got %0d want 0", dut.cancel_cnt); end
    n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL fc_valid: got %0b want 1", ms_to_ws_valid); end
    n_cmp++; if (ms_to_ws_bus[63:0] !== {32'h00000011, 32'h1c0000c4}) begin n_fail++; $display("FAIL fc_result: got %h want 000000111c0000c4", ms_to_ws_bus[63:0]); end
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL fc_drained: got %0b want 0", ms_to_ws_valid); end
  endtask

  task automatic test_flush_same_cycle();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(rand_pass(), 3'd2, 1'b1, 1'b1, 1'b1, 5'd6, 32'h1c000500, 32'h1c000100);
    tick();
    es_to_ms_valid = 1'b0;
    flush = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = $urandom;
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL fs_valid: got %0b want 0", ms_to_ws_valid); end
    tick();
    flush = 1'b0;
    data_sram_data_ok = 1'b0;
    #1;
    n_cmp++; if (dut.cancel_cnt !== 2'd0) begin n_fail++; $display("FAIL fs_cnt: got %0d want 0", dut.cancel_cnt); end
    n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL fs_allowin: got %0b want 1", ms_allowin); end
  endtask

  task automatic test_reset_mid_wait();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(rand_pass(), 3'd0, 1'b1, 1'b1, 1'b1, 5'd12, 32'h1c000601, 32'h1c000140);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    n_cmp++; if (ms_fwd_bus[38:37] !== 2'b11) begin n_fail++; $display("FAIL rw_fwd_wait: got %b want 11", ms_fwd_bus[38:37]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL rw_allowin: got %0b want 1", ms_allowin); end
    n_cmp++; if (ms_fwd_bus !== 39'd0) begin n_fail++; $display("FAIL rw_fwd: got %h want 0", ms_fwd_bus); end
    n_cmp++; if (dut.cancel_cnt !== 2'd0) begin n_fail++; $display("FAIL rw_cnt: got %0d want 0", dut.cancel_cnt); end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h80808080;
    #1;
    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL rw_late_valid: got %0b want 0", ms_to_ws_valid); end
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    n_cmp++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL rw_late_allowin: got %0b want 1", ms_allowin); end
  endtask

  // Transaction-level model: at most one instruction in the stage, an in-order SRAM whose
  // responses carry request ids, and responses for killed requests simply never match.
  task automatic test_random();
    int          sq_id[$];
    logic [31:0] sq_data[$];
    int          next_id;
    logic        occ, cur_load, cur_mreq, cur_we, has_resp;
    logic [4:0]  cur_dest;
    int          cur_id;
    logic [MS-1:0] cur_exp;
    logic        done, exp_valid, exp_allowin, exp_wait, exp_fwe, resp_mine, drained;
    int          kind;
    logic [2:0]  t;
    logic [31:0] addr, pcv, rd;
    logic [4:0]  d;
    logic        we;
    logic [PASS_WD-1:0] p;
    next_id = 0; occ = 1'b0; has_resp = 1'b0; cur_id = -1; drained = 1'b0;
    cur_load = 1'b0; cur_mreq = 1'b0; cur_we = 1'b0; cur_dest = 5'd0; cur_exp = '0;
    for (int cyc = 0; cyc < 2400; cyc++) begin
      if (cyc >= 2000 && !occ && sq_id.size() == 0) begin
        drained = 1'b1;
        break;
      end
      kind = (sq_id.size() >= 3) ? 0 : int'($urandom_range(0, 2));
      t = 3'($urandom_range(0, 7));
      addr = $urandom;
      if (t == 3'd1 || t == 3'd5) addr[0] = 1'b0;
      pcv = $urandom;
      d = 5'($urandom_range(0, 31));
      we = (kind == 1) ? 1'b1 : (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      rd = $urandom;
      p = rand_pass();
      es_to_ms_bus = mk_bus(p, t, kind == 1, kind != 0, we, d, addr, pcv);
      if (cyc < 2000) begin
        es_to_ms_valid = 1'($urandom_range(0, 1));
        ws_allowin = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 19) == 0);
        data_sram_data_ok = (sq_id.size() != 0) && ($urandom_range(0, 1) == 1);
      end else begin
        es_to_ms_valid = 1'b0;
        ws_allowin = 1'b1;
        flush = 1'b0;
        data_sram_data_ok = (sq_id.size() != 0);
      end
      data_sram_rdata = data_sram_data_ok ? sq_data[0] : $urandom;
      #1;
      resp_mine = data_sram_data_ok && occ && cur_mreq && (sq_id[0] == cur_id);
      done = occ && (!cur_mreq || has_resp || resp_mine);
      exp_valid = done && !flush;
      exp_allowin = !occ || (done && ws_allowin);
      exp_wait = occ && cur_load && !done;
      exp_fwe = occ && cur_we && (cur_dest != 5'd0);
      n_cmp++; if (ms_to_ws_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid c%0d: got %0b want %0b", cyc, ms_to_ws_valid, exp_valid); end
      n_cmp++; if (ms_allowin !== exp_allowin) begin n_fail++; $display("FAIL rnd_allowin c%0d: got %0b want %0b", cyc, ms_allowin, exp_allowin); end
      n_cmp++; if (ms_fwd_bus[38:37] !== {exp_fwe, exp_wait}) begin n_fail++; $display("FAIL rnd_fwd_flags c%0d: got %b want %b", cyc, ms_fwd_bus[38:37], {exp_fwe, exp_wait}); end
      if (exp_valid) begin
        n_cmp++; if (ms_to_ws_bus !== cur_exp) begin n_fail++; $display("FAIL rnd_bus c%0d: got %h want %h", cyc, ms_to_ws_bus, cur_exp); end
      end
      if (data_sram_data_ok) begin
        void'(sq_id.pop_front());
        void'(sq_data.pop_front());
      end
      if (flush || (done && ws_allowin)) occ = 1'b0;
      else if (resp_mine) has_resp = 1'b1;
      if (es_to_ms_valid && exp_allowin && !flush) begin
        occ = 1'b1;
        has_resp = 1'b0;
        cur_load = (kind == 1);
        cur_mreq = (kind != 0);
        cur_we = we;
        cur_dest = d;
        cur_exp = {p, we, d, (kind == 1) ? ref_load(t, addr, rd) : addr, pcv};
        if (kind != 0) begin
          cur_id = next_id;
          sq_id.push_back(next_id);
          sq_data.push_back(rd);
          next_id++;
        end
      end
      tick();
    end
    n_cmp++; if (drained !== 1'b1) begin n_fail++; $display("FAIL rnd_drain: got %0b want 1", drained); end
    idle();
    #1;
    n_cmp++; if (dut.cancel_cnt !== 2'd0) begin n_fail++; $display("FAIL rnd_cnt_end: got %0d want 0", dut.cancel_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait(3'd0, 32'hFFFFFF80);
    test_load_wait(3'd4, 32'h00000080);
    test_buffered();
    test_flush_cancel();
    test_flush_same_cycle();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
